pixel_array_ctrl: RTL and testbench

- Sequencer and readout stage for the 2x2 pixel array.
- Runs one frame per start request: ERASE, EXPOSE, CONVERT, READ row 1, READ row 2.
- During CONVERT it generates the conversion counter that the top level drives onto the shared DATA buses. During READ it captures the latched pixel codes.
- Streams the four captured codes downstream over a valid/ready interface.

---
 rtl/pixel_array_ctrl_if.sv | 13 +
 rtl/pixel_array_ctrl.sv | 156 +++++++++++++++
 tb/tb_pixel_array_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_array_ctrl_if.sv
// Pixel stream interface: one captured pixel code plus its index, valid/ready handshake.
// The controller drives it through the master modport; the downstream consumer uses slave.
interface pixel_array_ctrl_if #(
  parameter int DW = 8
);
  logic [DW-1:0] px_data;
  logic [1:0]    px_index;
  logic          px_valid;
  logic          px_ready;

  modport master (output px_data, px_index, px_valid, input px_ready);
  modport slave  (input px_data, px_index, px_valid, output px_ready);
endinterface

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the 2x2 pixel array: erase, expose, ramp conversion, two-row readout,
// then streams the four latched codes out. All outputs are registers decoded from the next state.
module pixel_array_ctrl #(
  parameter int DW        = 8,
  parameter int C_ERASE   = 5,
  parameter int C_EXPOSE  = 255,
  parameter int C_CONVERT = 255,
  parameter int C_READ    = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      erase,
  output logic                      expose,
  output logic                      convert,
  output logic                      read1,
  output logic                      read2,
  output logic                      data_oe,
  output logic [DW-1:0]             cnt_drive,
  input  logic [DW-1:0]             data1,
  input  logic [DW-1:0]             data2,
  input  logic [DW-1:0]             data3,
  input  logic [DW-1:0]             data4,
  pixel_array_ctrl_if.master        px,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int M_LONG  = (C_EXPOSE > C_CONVERT + 1) ? C_EXPOSE : C_CONVERT + 1;
  localparam int M_SHORT = (C_ERASE > C_READ) ? C_ERASE : C_READ;
  localparam int PMAX    = (M_LONG > M_SHORT) ? M_LONG : M_SHORT;
  localparam int PW      = $clog2(PMAX + 1);

  localparam logic [PW-1:0] LAST_ERASE  = PW'(C_ERASE - 1);
  localparam logic [PW-1:0] LAST_EXPOSE = PW'(C_EXPOSE - 1);
  localparam logic [PW-1:0] LAST_CONV   = PW'(C_CONVERT);
  localparam logic [PW-1:0] LAST_READ   = PW'(C_READ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ1, S_READ2, S_STREAM
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [DW-1:0]   cap_q [4];
  logic [DW-1:0]   cap_d [4];
  logic [DW-1:0]   px_data_q, px_data_d;
  logic [1:0]      px_idx_q, px_idx_d;
  logic [1:0]      nxt_idx;
  logic            px_valid_q;
  logic            frame_done_d, frame_done_q;
  logic            erase_q, expose_q, conv_q, read1_q, read2_q, busy_q;
  logic [DW-1:0]   cnt_q;
  logic            hs;

  always_comb begin
    state_d      = state_q;
    phase_d      = '0;
    cap_d        = cap_q;
    px_data_d    = px_data_q;
    px_idx_d     = px_idx_q;
    frame_done_d = 1'b0;
    hs           = px_valid_q & px.px_ready;
    nxt_idx      = px_idx_q + 2'd1;

    case (state_q)
      S_IDLE:    if (start) state_d = S_ERASE;
      S_ERASE:   if (phase_q == LAST_ERASE) state_d = S_EXPOSE;
      S_EXPOSE:  if (phase_q == LAST_EXPOSE) state_d = S_CONVERT;
      S_CONVERT: if (phase_q == LAST_CONV) state_d = S_READ1;
      S_READ1: begin
        if (phase_q == LAST_READ) begin
          state_d  = S_READ2;
          cap_d[0] = data1;
          cap_d[2] = data3;
        end
      end
      S_READ2: begin
        if (phase_q == LAST_READ) begin
          state_d   = S_STREAM;
          cap_d[1]  = data2;
          cap_d[3]  = data4;
          // Row 1 was captured a phase earlier, so pixel 1 is ready to present now.
          px_idx_d  = '0;
          px_data_d = cap_q[0];
        end
      end
      S_STREAM: begin
        if (hs) begin
          if (px_idx_q == 2'd3) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
            px_idx_d     = '0;
            px_data_d    = '0;
          end else begin
            px_idx_d  = nxt_idx;
            px_data_d = cap_q[nxt_idx];
          end
        end
      end
      default:   state_d = S_IDLE;
    endcase

    // Phase counts cycles spent in a timed state and restarts on every entry.
    if (state_d == state_q && state_q != S_IDLE && state_q != S_STREAM)
      phase_d = phase_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      for (int i = 0; i < 4; i++) cap_q[i] <= '0;
      px_data_q    <= '0;
      px_idx_q     <= '0;
      px_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      conv_q       <= 1'b0;
      read1_q      <= 1'b0;
      read2_q      <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cap_q        <= cap_d;
      px_data_q    <= px_data_d;
      px_idx_q     <= px_idx_d;
      px_valid_q   <= (state_d == S_STREAM);
      frame_done_q <= frame_done_d;
      erase_q      <= (state_d == S_ERASE);
      expose_q     <= (state_d == S_EXPOSE);
      conv_q       <= (state_d == S_CONVERT);
      read1_q      <= (state_d == S_READ1);
      read2_q      <= (state_d == S_READ2);
      busy_q       <= (state_d != S_IDLE);
      cnt_q        <= (state_d == S_CONVERT) ? DW'(phase_d) : '0;
    end
  end

  assign erase       = erase_q;
  assign expose      = expose_q;
  assign convert     = conv_q;
  assign data_oe     = conv_q;
  assign read1       = read1_q;
  assign read2       = read2_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign cnt_drive   = cnt_q;
  assign px.px_data  = px_data_q;
  assign px.px_index = px_idx_q;
  assign px.px_valid = px_valid_q;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl with shortened phase lengths; each scenario task
// drives its own stimulus and compares against hand-derived cycle expectations.
module tb_pixel_array_ctrl;
  localparam int DW = 8;
  localparam int E  = 2;
  localparam int X  = 4;
  localparam int C  = 15;
  localparam int R  = 2;
  localparam int B1 = E;
  localparam int B2 = B1 + X;
  localparam int B3 = B2 + C + 1;
  localparam int B4 = B3 + R;
  localparam int B5 = B4 + R;
  localparam int B6 = B5 + 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          erase, expose, convert, read1, read2, data_oe, busy, frame_done;
  logic [DW-1:0] cnt_drive;
  logic [DW-1:0] data1 = '0, data2 = '0, data3 = '0, data4 = '0;
  logic [8:0]    ctrl;

  int vectors = 0;
  int miscompares = 0;

  pixel_array_ctrl_if #(.DW(DW)) pif ();

  pixel_array_ctrl #(
    .DW(DW), .C_ERASE(E), .C_EXPOSE(X), .C_CONVERT(C), .C_READ(R)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .erase(erase), .expose(expose), .convert(convert),
    .read1(read1), .read2(read2), .data_oe(data_oe),
    .cnt_drive(cnt_drive),
    .data1(data1), .data2(data2), .data3(data3), .data4(data4),
    .px(pif.master),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign ctrl = {erase, expose, convert, data_oe, read1, read2, pif.px_valid, busy, frame_done};

  // Expected control vector k cycles after the ERASE entry edge, px_ready held high.
  function automatic logic [8:0] exp_ctrl(int k);
    logic e, x, c, r1, r2, v, b, f;
    e  = (k >= 0)  && (k < B1);
    x  = (k >= B1) && (k < B2);
    c  = (k >= B2) && (k < B3);
    r1 = (k >= B3) && (k < B4);
    r2 = (k >= B4) && (k < B5);
    v  = (k >= B5) && (k < B6);
    b  = (k >= 0)  && (k < B6);
    f  = (k == B6);
    return {e, x, c, c, r1, r2, v, b, f};
  endfunction

  function automatic logic [DW-1:0] exp_cnt(int k);
    return ((k >= B2) && (k < B3)) ? DW'(k - B2) : '0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (pif.px_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    vectors++;
    if (pif.px_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_wait_valid: px_valid=%b after %0d cycles, required 1", tag, pif.px_valid, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    pif.px_ready = 1'b1;
    repeat (3) begin
      step();
      vectors++;
      if (ctrl !== 9'b0 || cnt_drive !== '0 || pif.px_data !== '0 || pif.px_index !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_hold: ctrl=%b cnt=%h px=%h idx=%0d, required all 0",
                 ctrl, cnt_drive, pif.px_data, pif.px_index);
      end
    end
    reset = 1'b1;
    repeat (20) begin
      step();
      vectors++;
      if (ctrl !== 9'b0 || cnt_drive !== '0 || pif.px_data !== '0 || pif.px_index !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_idle: ctrl=%b cnt=%h px=%h idx=%0d, required all 0",
                 ctrl, cnt_drive, pif.px_data, pif.px_index);
      end
    end
  endtask

  task automatic test_strobe_timing();
    logic [DW-1:0] sd [4];
    sd[0] = 8'h5A; sd[1] = 8'hA5; sd[2] = 8'h3C; sd[3] = 8'hC3;
    data1 = sd[0]; data2 = sd[1]; data3 = sd[2]; data4 = sd[3];
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= B6; k++) begin
      vectors++;
      if (ctrl !== exp_ctrl(k) || cnt_drive !== exp_cnt(k)) begin
        miscompares++;
        $display("FAIL timing_k%0d: ctrl=%b cnt=%0d, required ctrl=%b cnt=%0d",
                 k, ctrl, cnt_drive, exp_ctrl(k), exp_cnt(k));
      end
      if (k >= B5 && k < B6) begin
        vectors++;
        if (pif.px_index !== 2'(k - B5) || pif.px_data !== sd[k - B5]) begin
          miscompares++;
          $display("FAIL timing_stream_k%0d: idx=%0d data=%h, required idx=%0d data=%h",
                   k, pif.px_index, pif.px_data, k - B5, sd[k - B5]);
        end
      end
      step();
    end
  endtask

  task automatic test_capture();
    logic [DW-1:0] sd [4];
    sd[0] = 8'h11; sd[1] = 8'h22; sd[2] = 8'h33; sd[3] = 8'h44;
    data1 = sd[0]; data2 = sd[1]; data3 = sd[2]; data4 = sd[3];
    pif.px_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("capture");
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (pif.px_valid !== 1'b1 || pif.px_index !== 2'(i) || pif.px_data !== sd[i]) begin
        miscompares++;
        $display("FAIL capture_px%0d: valid=%b idx=%0d data=%h, required valid=1 idx=%0d data=%h",
                 i, pif.px_valid, pif.px_index, pif.px_data, i, sd[i]);
      end
      step();
    end
    vectors++;
    if (pif.px_valid !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL capture_done: valid=%b frame_done=%b busy=%b, required 0 1 0",
               pif.px_valid, frame_done, busy);
    end
  endtask

  task automatic test_backpressure();
    data1 = 8'h11; data2 = 8'h22; data3 = 8'h33; data4 = 8'h44;
    pif.px_ready = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("bp");
    vectors++;
    if (pif.px_index !== 2'd0 || pif.px_data !== 8'h11) begin
      miscompares++;
      $display("FAIL bp_px0: idx=%0d data=%h, required idx=0 data=11", pif.px_index, pif.px_data);
    end
    step();
    pif.px_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (pif.px_valid !== 1'b1 || pif.px_index !== 2'd1 || pif.px_data !== 8'h22) begin
        miscompares++;
        $display("FAIL bp_hold%0d: valid=%b idx=%0d data=%h, required valid=1 idx=1 data=22",
                 i, pif.px_valid, pif.px_index, pif.px_data);
      end
      if (i < 5) step();
    end
    pif.px_ready = 1'b1;
    step();
    vectors++;
    if (pif.px_index !== 2'd2 || pif.px_data !== 8'h33 || pif.px_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_px2: valid=%b idx=%0d data=%h, required valid=1 idx=2 data=33",
               pif.px_valid, pif.px_index, pif.px_data);
    end
    step();
    vectors++;
    if (pif.px_index !== 2'd3 || pif.px_data !== 8'h44 || pif.px_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_px3: valid=%b idx=%0d data=%h, required valid=1 idx=3 data=44",
               pif.px_valid, pif.px_index, pif.px_data);
    end
    step();
    vectors++;
    if (pif.px_valid !== 1'b0 || frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_done: valid=%b frame_done=%b, required 0 1", pif.px_valid, frame_done);
    end
    step();
    vectors++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_pulse: frame_done=%b busy=%b, required 0 0", frame_done, busy);
    end
  endtask

  task automatic test_back_to_back();
    pif.px_ready = 1'b1;
    start = 1'b1;
    step();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k <= B6; k++) begin
        vectors++;
        if (ctrl !== exp_ctrl(k) || cnt_drive !== exp_cnt(k)) begin
          miscompares++;
          $display("FAIL b2b_f%0d_k%0d: ctrl=%b cnt=%0d, required ctrl=%b cnt=%0d",
                   f, k, ctrl, cnt_drive, exp_ctrl(k), exp_cnt(k));
        end
        if (f == 1 && k == B6) start = 1'b0;
        step();
      end
    end
    vectors++;
    if (ctrl !== 9'b0) begin
      miscompares++;
      $display("FAIL b2b_stop: ctrl=%b, required 0", ctrl);
    end
  endtask

  task automatic test_reset_mid_convert();
    int n;
    pif.px_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (cnt_drive !== 8'd7 && n < 60) begin
      step();
      n++;
    end
    vectors++;
    if (cnt_drive !== 8'd7 || convert !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_reach: cnt=%0d convert=%b, required cnt=7 convert=1", cnt_drive, convert);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (ctrl !== 9'b0 || cnt_drive !== '0 || pif.px_data !== '0 || pif.px_index !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_mid_async: ctrl=%b cnt=%0d px=%h idx=%0d, required all 0",
               ctrl, cnt_drive, pif.px_data, pif.px_index);
    end
    step();
    step();
    reset = 1'b1;
    repeat (3) begin
      step();
      vectors++;
      if (ctrl !== 9'b0 || cnt_drive !== '0) begin
        miscompares++;
        $display("FAIL rst_mid_idle: ctrl=%b cnt=%0d, required 0 0", ctrl, cnt_drive);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= B6; k++) begin
      vectors++;
      if (ctrl !== exp_ctrl(k) || cnt_drive !== exp_cnt(k)) begin
        miscompares++;
        $display("FAIL rst_mid_frame_k%0d: ctrl=%b cnt=%0d, required ctrl=%b cnt=%0d",
                 k, ctrl, cnt_drive, exp_ctrl(k), exp_cnt(k));
      end
      step();
    end
  endtask

  initial begin
    pif.px_ready = 1'b1;
    test_reset();
    test_strobe_timing();
    test_capture();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_convert();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
